// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the timing controller and the pixel fetch block.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_ADDR_W   = 19;
  localparam int VGA_PIX_W    = 12;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep syncs and pixel qualifiers aligned with the frame-buffer read path.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= RST_VAL;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Turns VGA controller counters into frame-buffer reads and drives the DAC colour,
// with syncs delayed to match the read pipeline.
module vga_pixel_fetch import vga_pkg::*; #(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int SCALE_SHIFT = 1,
  parameter int RD_LATENCY  = 2,
  parameter int ADDR_W      = VGA_ADDR_W,
  parameter int PIX_W       = VGA_PIX_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_x_counter,
  input  logic [9:0]        i_y_counter,
  input  logic              i_video,
  input  logic              i_hsync_pulse,
  input  logic              i_vsync_pulse,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic [3:0]        o_red,
  output logic [3:0]        o_green,
  output logic [3:0]        o_blue,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_start
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [9:0]        X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        V_LIMIT   = 10'(V_ACTIVE);
  localparam logic [9:0]        ROW_MASK  = 10'((1 << SCALE_SHIFT) - 1);

  // S0: input capture
  logic [9:0] x_s0_reg, y_s0_reg;
  logic       video_s0_reg, hs_s0_reg, vs_s0_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_s0_reg     <= '0;
      y_s0_reg     <= '0;
      video_s0_reg <= 1'b0;
      hs_s0_reg    <= 1'b1;
      vs_s0_reg    <= 1'b1;
    end else begin
      x_s0_reg     <= i_x_counter;
      y_s0_reg     <= i_y_counter;
      video_s0_reg <= i_video;
      hs_s0_reg    <= i_hsync_pulse;
      vs_s0_reg    <= i_vsync_pulse;
    end
  end

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic              fs_s1_reg;

  logic              at_origin, run_now, rd_en_next, line_end, row_last;
  logic [9:0]        x_scaled, y_plus1;
  logic [ADDR_W-1:0] addr_next;

  // The transition clock itself already fetches, so pixel (0,0) is not lost.
  assign at_origin  = video_s0_reg && (x_s0_reg == 10'd0) && (y_s0_reg == 10'd0);
  assign run_now    = (state_reg == ST_RUN) || at_origin;
  assign rd_en_next = run_now && video_s0_reg;
  assign x_scaled   = x_s0_reg >> SCALE_SHIFT;
  assign addr_next  = line_base_reg + ADDR_W'(x_scaled);
  assign y_plus1    = y_s0_reg + 10'd1;
  assign line_end   = video_s0_reg && (x_s0_reg == X_LAST);
  assign row_last   = (y_plus1 & ROW_MASK) == 10'd0;

  // S1: FSM, incremental line base and read request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_WAIT;
      line_base_reg <= '0;
      o_rd_addr     <= '0;
      o_rd_en       <= 1'b0;
      fs_s1_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT: if (at_origin) state_reg <= ST_RUN;
        ST_RUN:  state_reg <= ST_RUN;
        default: state_reg <= ST_WAIT;
      endcase

      // Clearing throughout vertical blanking re-anchors the base even after a bad count.
      if (y_s0_reg >= V_LIMIT)
        line_base_reg <= '0;
      else if (line_end && row_last)
        line_base_reg <= line_base_reg + LINE_STEP;

      o_rd_en   <= rd_en_next;
      if (rd_en_next) o_rd_addr <= addr_next;
      fs_s1_reg <= at_origin;
    end
  end

  logic [1:0] sync_out;

  vga_delay_line #(
    .WIDTH   (2),
    .DEPTH   (RD_LATENCY + 2),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk  (i_clk),
    .srst (i_rst),
    .din  ({hs_s0_reg, vs_s0_reg}),
    .dout (sync_out)
  );

  assign o_hsync = sync_out[1];
  assign o_vsync = sync_out[0];

  logic [1:0] pix_out;
  logic       pix_valid, fs_aligned;

  // Qualifiers ride alongside the read so they arrive with i_rd_data.
  vga_delay_line #(
    .WIDTH   (2),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (2'b00)
  ) u_pix_dly (
    .clk  (i_clk),
    .srst (i_rst),
    .din  ({o_rd_en, fs_s1_reg}),
    .dout (pix_out)
  );

  assign pix_valid  = pix_out[1];
  assign fs_aligned = pix_out[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_frame_start <= 1'b0;
    end else begin
      if (pix_valid) begin
        o_red   <= i_rd_data[11:8];
        o_green <= i_rd_data[7:4];
        o_blue  <= i_rd_data[3:0];
      end else begin
        o_red   <= '0;
        o_green <= '0;
        o_blue  <= '0;
      end
      o_frame_start <= fs_aligned;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Drives a shrunken VGA raster into two fetch instances (2x2 scaled / latency 1, 1:1 / latency 4)
// and compares every output clock against a frame-level reference model.
module tb_vga_pixel_fetch;

  localparam int H   = 32;
  localparam int V   = 12;
  localparam int HT  = 40;
  localparam int HS0 = 34;
  localparam int HS1 = 38;
  localparam int VT  = 16;
  localparam int VS0 = 13;
  localparam int VS1 = 15;
  localparam int NE  = 3300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  xc, yc;
  logic        vid, hsp, vsp;

  logic [18:0] addr_a, addr_b;
  logic        en_a, en_b;
  logic [11:0] data_a, data_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE_SHIFT(1), .RD_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_x_counter(xc), .i_y_counter(yc), .i_video(vid),
    .i_hsync_pulse(hsp), .i_vsync_pulse(vsp), .o_rd_addr(addr_a), .o_rd_en(en_a),
    .i_rd_data(data_a), .o_red(r_a), .o_green(g_a), .o_blue(b_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_frame_start(fs_a));

  vga_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .SCALE_SHIFT(0), .RD_LATENCY(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_x_counter(xc), .i_y_counter(yc), .i_video(vid),
    .i_hsync_pulse(hsp), .i_vsync_pulse(vsp), .o_rd_addr(addr_b), .o_rd_en(en_b),
    .i_rd_data(data_b), .o_red(r_b), .o_green(g_b), .o_blue(b_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_frame_start(fs_b));

  // Frame-buffer models: contents random, all-ones when not read.
  logic [11:0] mem [0:511];
  logic [11:0] pipe_a;
  logic [11:0] pipe_b [0:3];

  always @(posedge clk) begin
    pipe_a    <= en_a ? mem[addr_a[8:0]] : 12'hFFF;
    pipe_b[0] <= en_b ? mem[addr_b[8:0]] : 12'hFFF;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign data_a = pipe_a;
  assign data_b = pipe_b[3];

  // Expected outputs indexed by DUT and by clock edge.
  logic [11:0] exp_rgb  [2][NE+8];
  logic        exp_hs   [2][NE+8];
  logic        exp_vs   [2][NE+8];
  logic        exp_fs   [2][NE+8];
  logic        exp_en   [2][NE+8];
  int          exp_addr [2][NE+8];
  bit          running;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int shf_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Registers what each DUT must show as a consequence of the inputs sampled at edge e.
  task automatic model_sample(input int e, input bit r, input int x, input int y,
                              input bit v, input bit h, input bit vs);
    bit origin, on;
    int l, s, a;
    origin = v && (x == 0) && (y == 0);
    for (int d = 0; d < 2; d++) begin
      l = lat_of(d);
      s = shf_of(d);
      if (r) begin
        for (int k = 0; k <= l + 2; k++) begin
          exp_rgb[d][e+k] = 12'h000;
          exp_hs[d][e+k]  = 1'b1;
          exp_vs[d][e+k]  = 1'b1;
          exp_fs[d][e+k]  = 1'b0;
        end
        exp_en[d][e]     = 1'b0;
        exp_en[d][e+1]   = 1'b0;
        exp_addr[d][e]   = 0;
        exp_addr[d][e+1] = 0;
      end else begin
        on = (running || origin) && v;
        a  = (y >> s) * (H >> s) + (x >> s);
        exp_en[d][e+1]   = on;
        exp_addr[d][e+1] = on ? a : exp_addr[d][e];
        exp_rgb[d][e+l+2] = on ? mem[a[8:0]] : 12'h000;
        exp_hs[d][e+l+2]  = h;
        exp_vs[d][e+l+2]  = vs;
        exp_fs[d][e+l+2]  = origin;
      end
    end
    if (r) running = 1'b0;
    else if (origin) running = 1'b1;
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, expv);
    end
  endtask

  initial begin
    int cx, cy, frame_no, rx, ry, rst_left, max_a, max_b;
    bit rst_now;

    for (int i = 0; i < 512; i++) mem[i] = 12'($urandom);
    cx       = $urandom_range(0, HT - 1);
    cy       = $urandom_range(0, VT - 1);
    rx       = $urandom_range(0, H - 1);
    ry       = $urandom_range(0, V - 1);
    frame_no = 0;
    rst_left = 0;
    max_a    = 0;
    max_b    = 0;
    running  = 1'b0;

    for (int e = 0; e < NE; e++) begin
      if (frame_no == 2 && cx == H / 2 && cy == V / 2) rst_left = 1;
      if (frame_no == 3 && cx == rx && cy == ry) rst_left = $urandom_range(1, 3);
      rst_now = (e < 3) || (rst_left > 0);
      if (rst_left > 0) rst_left--;

      rst = rst_now;
      xc  = 10'(cx);
      yc  = 10'(cy);
      vid = (cx < H) && (cy < V);
      hsp = !(cx >= HS0 && cx < HS1);
      vsp = !(cy >= VS0 && cy < VS1);
      model_sample(e, rst_now, cx, cy, vid, hsp, vsp);

      @(posedge clk);
      #1;
      chk("a_rgb",  e, 32'({r_a, g_a, b_a}), 32'(exp_rgb[0][e]));
      chk("a_hs",   e, 32'(hs_a),   32'(exp_hs[0][e]));
      chk("a_vs",   e, 32'(vs_a),   32'(exp_vs[0][e]));
      chk("a_fs",   e, 32'(fs_a),   32'(exp_fs[0][e]));
      chk("a_en",   e, 32'(en_a),   32'(exp_en[0][e]));
      chk("a_addr", e, 32'(addr_a), 32'(exp_addr[0][e]));
      chk("b_rgb",  e, 32'({r_b, g_b, b_b}), 32'(exp_rgb[1][e]));
      chk("b_hs",   e, 32'(hs_b),   32'(exp_hs[1][e]));
      chk("b_vs",   e, 32'(vs_b),   32'(exp_vs[1][e]));
      chk("b_fs",   e, 32'(fs_b),   32'(exp_fs[1][e]));
      chk("b_en",   e, 32'(en_b),   32'(exp_en[1][e]));
      chk("b_addr", e, 32'(addr_b), 32'(exp_addr[1][e]));
      if (en_a && int'(addr_a) > max_a) max_a = int'(addr_a);
      if (en_b && int'(addr_b) > max_b) max_b = int'(addr_b);

      cx++;
      if (cx == HT) begin
        cx = 0;
        cy++;
        if (cy == VT) cy = 0;
      end
      if (cx == 0 && cy == 0) begin
        frame_no++;
        $display("frame %0d begins at edge %0d (compared so far %0d)", frame_no, e + 1, n_cmp);
      end
    end

    // Largest address ever read is the last active pixel of the buffer.
    chk("a_max_addr", NE, 32'(max_a), 32'((V / 2) * (H / 2) - 1));
    chk("b_max_addr", NE, 32'(max_b), 32'(V * H - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
